// File: rtl/clk_period_meter_if.sv
// Result bundle of the slow-clock period meter.
// The meter takes the master side; a consumer or bench takes the slave side.
interface clk_period_meter_if #(
    parameter int CNT_W = 28
);
    logic             sig_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             valid;
    logic             locked;
    logic             timeout;

    modport master (
        input  sig_in,
        output period,
        output high_time,
        output valid,
        output locked,
        output timeout
    );

    modport slave (
        output sig_in,
        input  period,
        input  high_time,
        input  valid,
        input  locked,
        input  timeout
    );
endinterface

// File: rtl/clk_period_meter.sv
// Period / high-time meter for slow asynchronous inputs, in clk_100mhz cycles.
// Define CLK_PERIOD_METER_DUTY_EN to build the high-time (duty) measurement.
module clk_period_meter #(
    parameter int CNT_W   = 28,
    parameter int TIMEOUT = 50000000
) (
    input logic                clk_100mhz,
    input logic                rst,
    clk_period_meter_if.master mtr
);

    typedef enum logic [1:0] {
        S_WAIT,
        S_MEAS,
        S_TOUT
    } state_e;

    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] TO_V = CNT_W'(TIMEOUT);

    logic             s1_q;
    logic             s2_q;
    logic             sp_q;
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] period_q;
    logic             valid_q;
    logic             locked_q;
    logic             timeout_q;
    logic             rise;

    // Reset to 1 so a signal already high at reset is not seen as a rise.
    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            sp_q <= 1'b1;
        end else begin
            s1_q <= mtr.sig_in;
            s2_q <= s1_q;
            sp_q <= s2_q;
        end
    end

    assign rise  = s2_q & ~sp_q;
    assign cnt_d = cnt_q + ONE;

    // A rise wins over reaching the timeout count in the same cycle.
    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            state_q   <= S_WAIT;
            cnt_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                S_WAIT: begin
                    if (rise) begin
                        state_q <= S_MEAS;
                        cnt_q   <= ONE;
                    end
                end
                S_MEAS: begin
                    if (rise) begin
                        period_q <= cnt_q;
                        valid_q  <= 1'b1;
                        locked_q <= 1'b1;
                        cnt_q    <= ONE;
                    end else if (cnt_q == TO_V) begin
                        state_q   <= S_TOUT;
                        timeout_q <= 1'b1;
                        locked_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_TOUT: begin
                    if (rise) begin
                        state_q   <= S_MEAS;
                        timeout_q <= 1'b0;
                        cnt_q     <= ONE;
                    end
                end
                default: begin
                    state_q <= S_WAIT;
                end
            endcase
        end
    end

`ifdef CLK_PERIOD_METER_DUTY_EN
    logic             fall;
    logic [CNT_W-1:0] hi_q;
    logic [CNT_W-1:0] high_q;

    assign fall = ~s2_q & sp_q;

    // Without a fall since the last rise, the previous high count is reused.
    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            hi_q   <= '0;
            high_q <= '0;
        end else if (state_q == S_MEAS) begin
            if (fall) begin
                hi_q <= cnt_q;
            end
            if (rise) begin
                high_q <= hi_q;
            end
        end
    end

    assign mtr.high_time = high_q;
`else
    assign mtr.high_time = '0;
`endif

    assign mtr.period  = period_q;
    assign mtr.valid   = valid_q;
    assign mtr.locked  = locked_q;
    assign mtr.timeout = timeout_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Bench for clk_period_meter: event-level reference model driven by square
// waves, with the result expected three falling edges after each input bit.
module tb_clk_period_meter;

    localparam int CW = 28;
    localparam int TO = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    clk_period_meter_if #(.CNT_W(CW)) mtr ();

    clk_period_meter #(
        .CNT_W  (CW),
        .TIMEOUT(TO)
    ) dut (
        .clk_100mhz(clk),
        .rst       (rst),
        .mtr       (mtr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] per;
        logic [CW-1:0] hi;
        logic          v;
        logic          l;
        logic          t;
    } snap_t;

    snap_t pipe[$];
    int    vecs = 0;
    int    miss = 0;
    int    k = 0;
    int    m_last = 0;
    int    m_per = 0;
    int    m_hi = 0;
    int    m_hout = 0;
    bit    m_prev, m_have, m_tout, m_lock;

    function automatic snap_t observe();
        snap_t s;
        s.per = mtr.period;
        s.hi  = mtr.high_time;
        s.v   = mtr.valid;
        s.l   = mtr.locked;
        s.t   = mtr.timeout;
        return s;
    endfunction

    function void model_reset();
        m_prev = 1'b1;
        m_have = 1'b0;
        m_tout = 1'b0;
        m_lock = 1'b0;
        m_per  = 0;
        m_hi   = 0;
        m_hout = 0;
        pipe.delete();
        pipe.push_back('0);
        pipe.push_back('0);
    endfunction

    // Spec rules in terms of intervals between input edges.
    function void model_step(logic b);
        snap_t s;
        bit    v;
        v = 1'b0;
        k++;
        if (b && !m_prev) begin
            if (m_have && !m_tout) begin
                m_per  = k - m_last;
                m_hout = m_hi;
                m_lock = 1'b1;
                v      = 1'b1;
            end
            m_have = 1'b1;
            m_tout = 1'b0;
            m_last = k;
        end else if (m_have && !m_tout) begin
            if (!b && m_prev) m_hi = k - m_last;
            if (k - m_last == TO) begin
                m_tout = 1'b1;
                m_lock = 1'b0;
            end
        end
        m_prev = b;
        s.per  = CW'(m_per);
`ifdef CLK_PERIOD_METER_DUTY_EN
        s.hi   = CW'(m_hout);
`else
        s.hi   = '0;
`endif
        s.v    = v;
        s.l    = m_lock;
        s.t    = m_tout;
        pipe.push_back(s);
    endfunction

    task automatic tick(input logic b, output snap_t o, output snap_t e);
        @(negedge clk);
        o = observe();
        e = pipe.pop_front();
        mtr.sig_in = b;
        model_step(b);
    endtask

    task automatic reset_dut(input logic b);
        @(negedge clk);
        rst = 1'b1;
        mtr.sig_in = b;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        model_step(b);
    endtask

    task automatic test_reset();
        snap_t o, e;
        @(negedge clk);
        rst = 1'b1;
        mtr.sig_in = 1'b0;
        #1;
        o = observe();
        vecs++;
        if (o !== '0) begin
            miss++;
            $display("FAIL reset_state got %h want 0", o);
        end
        reset_dut(1'b0);
        for (int c = 0; c < 6; c++) begin
            tick(1'b0, o, e);
            vecs++;
            if (o !== e) begin
                miss++;
                $display("FAIL reset_idle k=%0d got %h want %h", k, o, e);
            end
        end
    endtask

    task automatic test_basic();
        snap_t o, e;
        int    nv = 0;
        snap_t lv = '0;
        int    want_hi;
        reset_dut(1'b0);
        for (int p = 0; p < 5; p++) begin
            for (int c = 0; c < 100; c++) begin
                tick(c < 50, o, e);
                vecs++;
                if (o !== e) begin
                    miss++;
                    $display("FAIL basic k=%0d got %h want %h", k, o, e);
                end
                if (o.v) begin
                    nv++;
                    lv = o;
                end
            end
        end
`ifdef CLK_PERIOD_METER_DUTY_EN
        want_hi = 50;
`else
        want_hi = 0;
`endif
        vecs++;
        if (nv != 4 || lv.per != 100 || lv.hi != CW'(want_hi) || !lv.l) begin
            miss++;
            $display("FAIL basic_result valids=%0d per=%0d hi=%0d lock=%b want 4/100/%0d/1",
                     nv, lv.per, lv.hi, lv.l, want_hi);
        end
    endtask

    task automatic test_high_at_reset();
        snap_t o, e;
        int    nv = 0;
        snap_t lv = '0;
        int    want_hi;
        reset_dut(1'b1);
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 60; c++) begin
                tick(c >= 30, o, e);
                vecs++;
                if (o !== e) begin
                    miss++;
                    $display("FAIL high_rst k=%0d got %h want %h", k, o, e);
                end
                if (o.v) begin
                    nv++;
                    lv = o;
                end
            end
        end
`ifdef CLK_PERIOD_METER_DUTY_EN
        want_hi = 30;
`else
        want_hi = 0;
`endif
        vecs++;
        if (nv != 2 || lv.per != 60 || lv.hi != CW'(want_hi)) begin
            miss++;
            $display("FAIL high_rst_result valids=%0d per=%0d hi=%0d want 2/60/%0d",
                     nv, lv.per, lv.hi, want_hi);
        end
    endtask

    task automatic test_timeout();
        snap_t o, e;
        int    nv = 0;
        snap_t lv = '0;
        reset_dut(1'b0);
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 100; c++) begin
                tick(c < 50, o, e);
                vecs++;
                if (o !== e) begin
                    miss++;
                    $display("FAIL tout_lock k=%0d got %h want %h", k, o, e);
                end
            end
        end
        for (int c = 0; c < 1100; c++) begin
            tick(1'b0, o, e);
            vecs++;
            if (o !== e) begin
                miss++;
                $display("FAIL tout_hold k=%0d got %h want %h", k, o, e);
            end
        end
        vecs++;
        if (o.t !== 1'b1 || o.l !== 1'b0 || o.per != 100) begin
            miss++;
            $display("FAIL tout_state t=%b l=%b per=%0d want 1/0/100", o.t, o.l, o.per);
        end
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 100; c++) begin
                tick(c < 50, o, e);
                vecs++;
                if (o !== e) begin
                    miss++;
                    $display("FAIL tout_recover k=%0d got %h want %h", k, o, e);
                end
                if (o.v) begin
                    nv++;
                    lv = o;
                end
            end
        end
        vecs++;
        if (nv != 2 || lv.per != 100 || o.t !== 1'b0) begin
            miss++;
            $display("FAIL tout_recover_result valids=%0d per=%0d t=%b want 2/100/0",
                     nv, lv.per, o.t);
        end
    endtask

    task automatic test_boundary();
        snap_t o, e;
        int    nt = 0;
        snap_t lv = '0;
        reset_dut(1'b0);
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < TO; c++) begin
                tick(c < 500, o, e);
                vecs++;
                if (o !== e) begin
                    miss++;
                    $display("FAIL boundary k=%0d got %h want %h", k, o, e);
                end
                if (o.t) nt++;
                if (o.v) lv = o;
            end
        end
        vecs++;
        if (nt != 0 || lv.per != CW'(TO)) begin
            miss++;
            $display("FAIL boundary_result tout_cycles=%0d per=%0d want 0/%0d", nt, lv.per, TO);
        end
    endtask

    task automatic test_mid_reset();
        snap_t o, e;
        int    nv = 0;
        reset_dut(1'b0);
        for (int c = 0; c < 240; c++) begin
            tick((c % 100) < 50, o, e);
            vecs++;
            if (o !== e) begin
                miss++;
                $display("FAIL mid_pre k=%0d got %h want %h", k, o, e);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        o = observe();
        vecs++;
        if (o !== '0) begin
            miss++;
            $display("FAIL mid_reset_clear got %h want 0", o);
        end
        reset_dut(1'b0);
        for (int c = 0; c < 300; c++) begin
            tick((c % 100) < 50, o, e);
            vecs++;
            if (o !== e) begin
                miss++;
                $display("FAIL mid_post k=%0d got %h want %h", k, o, e);
            end
            if (o.v) nv++;
        end
        vecs++;
        if (nv != 2) begin
            miss++;
            $display("FAIL mid_post_valids got %0d want 2", nv);
        end
    endtask

    task automatic test_random();
        snap_t o, e;
        int    pw, hw;
        reset_dut(1'b0);
        for (int p = 0; p < 14; p++) begin
            pw = int'($urandom_range(2, 1200));
            hw = int'($urandom_range(1, pw - 1));
            for (int c = 0; c < pw; c++) begin
                tick(c < hw, o, e);
                vecs++;
                if (o !== e) begin
                    miss++;
                    $display("FAIL random k=%0d P=%0d H=%0d got %h want %h", k, pw, hw, o, e);
                end
            end
        end
        for (int c = 0; c < 8; c++) begin
            tick(1'b0, o, e);
            vecs++;
            if (o !== e) begin
                miss++;
                $display("FAIL random_tail k=%0d got %h want %h", k, o, e);
            end
        end
    endtask

    initial begin
        mtr.sig_in = 1'b0;
        test_reset();
        test_basic();
        test_high_at_reset();
        test_timeout();
        test_boundary();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
